mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: size, 32, data/address width in bits.
REQ-002 Parameter: LAT, 2, shared-memory access latency in cycles (>=1).
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 req0_i  in  1  instruction-side request; held until done0_o.
REQ-006 addr0_i  in  size  instruction-side address.
REQ-007 req1_i  in  1  data-side request; held until done1_o.
REQ-008 addr1_i  in  size  data-side address.
REQ-009 we1_i  in  1  data-side write enable.
REQ-010 wdata1_i  in  size  data-side write data.
REQ-011 gnt0_o / gnt1_o  out  1  requester owns the memory port.
REQ-012 done0_o / done1_o  out  1  one-cycle completion pulse.
REQ-013 rdata_o  out  size  registered read data; valid while doneX_o=1.
REQ-014 select_o  out  1  2:1 mux select (0 = requester 0, 1 = requester 1).
REQ-015 mem_en_o, mem_we_o  out  1  memory enable, write enable.
REQ-016 mem_addr_o, mem_wdata_o  out  size  latched address and write data.
REQ-017 mem_rdata_i  in  size  memory read data, valid on the last access cycle.

Function
REQ-018 FSM has three states: IDLE, ACCESS, RESP.
REQ-019 IDLE: if any reqX_i=1, latch owner, address, we and wdata; go to ACCESS next cycle; else stay in IDLE.
REQ-020 ACCESS: mem_en_o=1 and gntX_o=1 for the owner for exactly LAT cycles; mem_addr_o, mem_we_o and mem_wdata_o stay stable.
REQ-021 Latency counter loads LAT-1 on entry to ACCESS and decrements each cycle; at 0, capture mem_rdata_i into rdata_o and go to RESP.
REQ-022 RESP: doneX_o=1 for the owner for one cycle, gntX_o=0, mem_en_o=0; then go to IDLE.
REQ-023 Minimum request-to-done latency: LAT+1 cycles after the IDLE sampling edge; back-to-back turnaround is LAT+2 cycles.
REQ-024 Requester 0 is read-only; mem_we_o=0 whenever the owner is requester 0.
REQ-025 On a write, rdata_o holds its previous value.
REQ-026 select_o equals the latched owner in ACCESS and RESP, and holds its last value in IDLE.
REQ-027 A request still asserted in the cycle after RESP counts as a new request.
REQ-028 Input changes during ACCESS are ignored.
REQ-029 At most one gntX_o is asserted at any time.
REQ-030 At most one doneX_o is asserted at any time.

Reset
REQ-031 rst_i=0 forces IDLE immediately (asynchronously) and aborts any in-flight access with no done pulse.
REQ-032 Reset values: all gnt, done and mem_* outputs 0; rdata_o=0; select_o=0; counter=0; last-served pointer=1.

Configuration
REQ-033 Macro MEM_ARB_RR_EN defined: round-robin arbitration; on a simultaneous request, grant the requester not served last; the pointer updates on entry to ACCESS.
REQ-034 Macro MEM_ARB_RR_EN undefined: fixed priority, requester 1 always wins; the pointer logic is absent.

Structure
REQ-035 Shared package holds the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the owner constants REQ_I=1'b0, REQ_D=1'b1.
REQ-036 One sub-module, lat_counter (load, decrement, zero flag), holds the latency count; select_o drives the existing 2:1 mux.

Verification
REQ-037 Reset, then req0_i=1 with addr0_i=0x10 and mem_rdata_i=0xDEADBEEF (LAT=2) -> gnt0_o high 2 cycles, done0_o pulses with rdata_o=0xDEADBEEF.
REQ-038 req1_i=1, we1_i=1, addr1_i=0x20, wdata1_i=0x55 -> mem_we_o=1 and mem_addr_o=0x20 for 2 cycles, done1_o pulses, rdata_o unchanged.
REQ-039 req0_i and req1_i both held high for 4 transactions, with RR -> owners 0,1,0,1; without RR -> owners 1,1,1,1.
REQ-040 rst_i driven low in the second ACCESS cycle -> all outputs 0 immediately, no done pulse, IDLE after release.
REQ-041 req1_i asserted mid-ACCESS of requester 0 -> requester 1 is granted only after done0_o, and select_o switches 0 to 1.
REQ-042 LAT=1 build, single read -> gnt asserted 1 cycle, done on the following cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM encoding, owner constants
// and the latency-counter width helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Bits needed to hold LAT-1; never narrower than one bit.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Access-latency down-counter: loads a start value, counts down to zero and
// flags zero so the arbiter knows the last access cycle has arrived.
module lat_counter #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction port (read-only) and a data port onto one shared
// memory port. Define MEM_ARB_RR_EN for round-robin; default is data-side priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int size = 32,
    parameter int LAT  = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req0_i,
    input  logic [size-1:0] addr0_i,
    input  logic            req1_i,
    input  logic [size-1:0] addr1_i,
    input  logic            we1_i,
    input  logic [size-1:0] wdata1_i,
    output logic            gnt0_o,
    output logic            gnt1_o,
    output logic            done0_o,
    output logic            done1_o,
    output logic [size-1:0] rdata_o,
    output logic            select_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [size-1:0] mem_addr_o,
    output logic [size-1:0] mem_wdata_o,
    input  logic [size-1:0] mem_rdata_i,
    output state_t          state_o
);

    localparam int CW = cnt_width(LAT);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LAT - 1);

    state_t          state_q, state_d;
    logic            accept;
    logic            pick;
    logic            owner_q;
    logic            we_q;
    logic [size-1:0] addr_q;
    logic [size-1:0] wdata_q;
    logic [size-1:0] rdata_q;
    logic            cnt_zero;

    assign accept = (state_q == IDLE) && (req0_i || req1_i);

`ifdef MEM_ARB_RR_EN
    // Last-served pointer: a simultaneous request goes to the other side.
    logic last_q;

    always_comb begin
        pick = req1_i ? REQ_D : REQ_I;
        if (req0_i && req1_i) begin
            pick = ~last_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= pick;
        end
    end
`else
    assign pick = req1_i ? REQ_D : REQ_I;
`endif

    // Request fields are captured once at acceptance and held through RESP.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            owner_q <= REQ_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            owner_q <= pick;
            we_q    <= (pick == REQ_D) && we1_i;
            addr_q  <= (pick == REQ_D) ? addr1_i : addr0_i;
            wdata_q <= (pick == REQ_D) ? wdata1_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if ((state_q == ACCESS) && cnt_zero && !we_q) begin
            rdata_q <= mem_rdata_i;
        end
    end

    lat_counter #(.W(CW)) u_lat_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (accept),
        .load_val_i (LOAD_VAL),
        .dec_i      (state_q == ACCESS),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  if (cnt_zero) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt0_o   = 1'b0;
        gnt1_o   = 1'b0;
        done0_o  = 1'b0;
        done1_o  = 1'b0;
        mem_en_o = 1'b0;
        mem_we_o = 1'b0;
        unique case (state_q)
            ACCESS: begin
                mem_en_o = 1'b1;
                mem_we_o = we_q;
                gnt0_o   = (owner_q == REQ_I);
                gnt1_o   = (owner_q == REQ_D);
            end
            RESP: begin
                done0_o = (owner_q == REQ_I);
                done1_o = (owner_q == REQ_D);
            end
            default: ;
        endcase
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign select_o    = owner_q;
    assign state_o     = state_q;

endmodule
